onehot_arb_mux: RTL and testbench



---
 rtl/gpc_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 39 +++
 rtl/onehot_arb_mux.sv | 70 +++++++
 tb/tb_onehot_arb_mux.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gpc_arb_pkg.sv
// Shared arbitration definitions for the general-purpose channel arbiters.
// Holds the arbitration mode encoding and the one-hot to index encoder.
package gpc_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned ONEHOT_MAXN = 64;

    // OR of the indices of all set bits; exact for a one-hot (or zero) input.
    function automatic int unsigned onehot2idx(input logic [ONEHOT_MAXN-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ONEHOT_MAXN; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: round-robin scan from ptr, or fixed priority.
// The request vector is doubled so the wrapped scan is one linear priority pass.
module rr_pick
    import gpc_arb_pkg::*;
#(
    parameter  int NR = 2,
    localparam int IW = $clog2(NR)
) (
    input  logic [NR-1:0] req,
    input  logic [IW-1:0] ptr,
    input  arb_mode_e     mode,
    output logic [NR-1:0] grant
);

    logic [2*NR-1:0] req2;
    logic [2*NR-1:0] window;
    logic [2*NR-1:0] masked;
    int unsigned     base;
    logic            found;

    always_comb begin
        base   = (mode == ARB_RR) ? 32'(ptr) : 32'd0;
        req2   = {req, req};
        window = '0;
        for (int unsigned j = 0; j < 2 * NR; j++) begin
            window[j] = (j >= base) && (j < base + NR);
        end
        masked = req2 & window;
        grant  = '0;
        found  = 1'b0;
        for (int unsigned j = 0; j < 2 * NR; j++) begin
            if (masked[j] && !found) begin
                grant[j % NR] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_arb_mux.sv
// Arbitrates NR valid/ready channels onto one registered output channel.
// Grant is generated internally, so the data select is always one-hot or zero.
module onehot_arb_mux
    import gpc_arb_pkg::*;
#(
    parameter  int NR = 2,
    parameter  int DW = 32,
    parameter  int RR = 1,
    localparam int IW = $clog2(NR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NR-1:0]    in_valid,
    output logic [NR-1:0]    in_ready,
    input  logic [NR*DW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [NR-1:0]    out_grant,
    output logic [IW-1:0]    out_idx
);

    localparam arb_mode_e MODE = (RR != 0) ? ARB_RR : ARB_FIXED;

    logic [IW-1:0] ptr;
    logic [NR-1:0] g;
    logic [IW-1:0] g_idx;
    logic [DW-1:0] mux_data;
    logic          load;

    rr_pick #(.NR(NR)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .mode  (MODE),
        .grant (g)
    );

    // rst_n gates load so no input is accepted while reset is held.
    assign load     = rst_n && (!out_valid || out_ready) && (|in_valid);
    assign in_ready = load ? g : '0;
    assign g_idx    = IW'(onehot2idx(ONEHOT_MAXN'(g)));

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            mux_data = mux_data | (in_data[i*DW +: DW] & {DW{g[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_grant <= '0;
            out_idx   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_grant <= g;
            out_idx   <= g_idx;
            if (MODE == ARB_RR) begin
                ptr <= (g_idx == IW'(NR - 1)) ? '0 : g_idx + IW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_onehot_arb_mux.sv
// Directed bench for onehot_arb_mux across four configurations.
// Expected values are hand-derived constants.
module tb_onehot_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: NR=2 RR   b: NR=4 RR   c: NR=4 fixed   d: NR=3 RR
    logic [1:0]  a_iv, a_ir, a_og;  logic [15:0] a_id;  logic a_ov, a_or;  logic [7:0] a_od;  logic [0:0] a_ox;
    logic [3:0]  b_iv, b_ir, b_og;  logic [31:0] b_id;  logic b_ov, b_or;  logic [7:0] b_od;  logic [1:0] b_ox;
    logic [3:0]  c_iv, c_ir, c_og;  logic [31:0] c_id;  logic c_ov, c_or;  logic [7:0] c_od;  logic [1:0] c_ox;
    logic [2:0]  d_iv, d_ir, d_og;  logic [23:0] d_id;  logic d_ov, d_or;  logic [7:0] d_od;  logic [1:0] d_ox;

    onehot_arb_mux #(.NR(2), .DW(8), .RR(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_grant(a_og), .out_idx(a_ox));
    onehot_arb_mux #(.NR(4), .DW(8), .RR(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_grant(b_og), .out_idx(b_ox));
    onehot_arb_mux #(.NR(4), .DW(8), .RR(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_grant(c_og), .out_idx(c_ox));
    onehot_arb_mux #(.NR(3), .DW(8), .RR(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_grant(d_og), .out_idx(d_ox));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_iv = 2'b11; a_id = {8'h22, 8'h11}; a_or = 1'b1;
        b_iv = '0; b_id = {8'h43, 8'h42, 8'h41, 8'h40}; b_or = 1'b1;
        c_iv = '0; c_id = {8'h53, 8'h52, 8'h51, 8'h50}; c_or = 1'b1;
        d_iv = '0; d_id = {8'h32, 8'h31, 8'h30}; d_or = 1'b1;

        // Reset held with requests pending
        #2;
        chk("rst_ov",    32'(a_ov), 32'd0);
        chk("rst_ir",    32'(a_ir), 32'd0);
        chk("rst_og",    32'(a_og), 32'd0);
        chk("rst_od",    32'(a_od), 32'd0);
        chk("rst_ox",    32'(a_ox), 32'd0);
        #20;
        rst_n = 1'b1;
        #1;
        chk("rel_ir",    32'(a_ir), 32'h1);
        tick();
        chk("rel_ov",    32'(a_ov), 32'd1);
        chk("rel_od",    32'(a_od), 32'h11);
        chk("rel_og",    32'(a_og), 32'h1);
        chk("rel_ox",    32'(a_ox), 32'd0);
        a_iv = '0;

        // Round-robin fairness, all channels requesting
        b_iv = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_ov", 32'(b_ov), 32'd1);
            chk("rr_ox", 32'(b_ox), 32'(k % 4));
            chk("rr_og", 32'(b_og), 32'(1 << (k % 4)));
            chk("rr_od", 32'(b_od), 32'h40 + 32'(k % 4));
        end
        b_iv = '0;
        tick();
        chk("rr_drain_ov", 32'(b_ov), 32'd0);
        chk("rr_drain_ox", 32'(b_ox), 32'd1);

        // Fixed priority: ch1 always beats ch3
        c_iv = 4'b1010;
        #1;
        chk("fp_ir0", 32'(c_ir), 32'h2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_ox", 32'(c_ox), 32'd1);
            chk("fp_od", 32'(c_od), 32'h51);
            chk("fp_ir", 32'(c_ir), 32'h2);
        end

        // Backpressure
        c_iv = 4'b0100; c_id[23:16] = 8'hA5;
        tick();
        chk("bp_load_od", 32'(c_od), 32'hA5);
        c_or = 1'b0; c_id[23:16] = 8'h5A;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ir", 32'(c_ir), 32'h0);
            tick();
            chk("bp_ov", 32'(c_ov), 32'd1);
            chk("bp_od", 32'(c_od), 32'hA5);
            chk("bp_ox", 32'(c_ox), 32'd2);
        end
        c_or = 1'b1;
        #1;
        chk("bp_rel_ir", 32'(c_ir), 32'h4);
        tick();
        chk("bp_rel_od", 32'(c_od), 32'h5A);
        c_iv = '0;
        tick();
        chk("bp_idle_ov", 32'(c_ov), 32'd0);
        chk("bp_idle_od", 32'(c_od), 32'h5A);
        chk("bp_idle_og", 32'(c_og), 32'h4);

        // Non-power-of-2 wrap: grant ch1 so ptr lands on 2
        d_iv = 3'b010;
        tick();
        chk("np_pre_ox", 32'(d_ox), 32'd1);
        d_iv = 3'b101;
        #1;
        chk("np_ir_p2", 32'(d_ir), 32'h4);
        tick();
        chk("np_ox_2",  32'(d_ox), 32'd2);
        chk("np_od_2",  32'(d_od), 32'h32);
        chk("np_ir_p0", 32'(d_ir), 32'h1);
        tick();
        chk("np_ox_0",  32'(d_ox), 32'd0);
        chk("np_od_0",  32'(d_od), 32'h30);
        tick();
        chk("np_ox_2b", 32'(d_ox), 32'd2);
        tick();
        chk("np_ox_0b", 32'(d_ox), 32'd0);

        // Async reset mid-stream; ptr is 1 here, must return to 0
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ov", 32'(d_ov), 32'd0);
        chk("ar_og", 32'(d_og), 32'd0);
        chk("ar_od", 32'(d_od), 32'd0);
        chk("ar_ir", 32'(d_ir), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ar_ptr_ir", 32'(d_ir), 32'h1);
        tick();
        chk("ar_post_ox", 32'(d_ox), 32'd0);
        chk("ar_post_ov", 32'(d_ov), 32'd1);
        d_iv = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
